// File: rtl/ll_online_sequencer.sv
// ll_online_sequencer: bring-up controller for the logic-link auto-sync path.
// After link_up it latches the X/Y/Z delay configuration, raises tx_online
// and then rx_online, waits for the delayed echoes from ll_auto_sync (with an
// optional per-phase timeout), and reports link_ready. Failed attempts back
// off and retry until cfg_max_retry is exhausted, which lands in a sticky
// ERROR state that only clear_error leaves.
// Optional statistics outputs (stat_drop_cnt, stat_last_fail) are built when
// the macro LL_ONLINE_SEQ_STATS_EN is defined.
module ll_online_sequencer #(
    parameter int unsigned BACKOFF_CYCLES = 16,   // 1 .. 65536
    parameter int unsigned RETRY_W        = 4
) (
    input  logic               clk_wr,
    input  logic               rst_wr,
    input  logic               link_up,
    input  logic [15:0]        cfg_delay_x,
    input  logic [15:0]        cfg_delay_y,
    input  logic [15:0]        cfg_delay_z,
    input  logic [15:0]        cfg_timeout,
    input  logic [RETRY_W-1:0] cfg_max_retry,
    input  logic               clear_error,
    input  logic               tx_online_delay,
    input  logic               rx_online_delay,
    output logic               tx_online,
    output logic               rx_online,
    output logic [15:0]        delay_x_value,
    output logic [15:0]        delay_y_value,
    output logic [15:0]        delay_z_value,
    output logic               link_ready,
    output logic               seq_error,
`ifdef LL_ONLINE_SEQ_STATS_EN
    output logic [15:0]        stat_drop_cnt,
    output logic [1:0]         stat_last_fail,
`endif
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_TX_UP   = 3'd2,
        ST_RX_UP   = 3'd3,
        ST_READY   = 3'd4,
        ST_BACKOFF = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    // Timer value on the last BACKOFF cycle (timer starts at 0 on entry).
    localparam logic [15:0]        BACKOFF_LAST = 16'(BACKOFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);

    state_t             state_q;
    logic               tx_online_q;
    logic               rx_online_q;
    logic               link_ready_q;
    logic               seq_error_q;
    logic [RETRY_W-1:0] retry_q;
    logic [15:0]        delay_x_q;
    logic [15:0]        delay_y_q;
    logic [15:0]        delay_z_q;
    logic [15:0]        timer_q;
`ifdef LL_ONLINE_SEQ_STATS_EN
    logic [15:0]        drop_cnt_q;
    logic [1:0]         last_fail_q;
`endif

    // Saturating next values for the phase timer and the retry counter.
    logic [15:0]        timer_sat_d;
    logic [RETRY_W-1:0] retry_sat_d;
    logic               timeout_hit;

    // Saturating increments and the per-phase timeout compare (0 disables it).
    always_comb begin
        timer_sat_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        retry_sat_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_ONE;
        timeout_hit = (cfg_timeout != 16'd0) && (timer_q == cfg_timeout - 16'd1);
    end

    // Sequencer FSM; every output is a register updated together with the state.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q      <= ST_IDLE;
            tx_online_q  <= 1'b0;
            rx_online_q  <= 1'b0;
            link_ready_q <= 1'b0;
            seq_error_q  <= 1'b0;
            retry_q      <= '0;
            delay_x_q    <= 16'd0;
            delay_y_q    <= 16'd0;
            delay_z_q    <= 16'd0;
            timer_q      <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
            drop_cnt_q   <= 16'd0;
            last_fail_q  <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_online_q  <= 1'b0;
                    rx_online_q  <= 1'b0;
                    link_ready_q <= 1'b0;
                    timer_q      <= 16'd0;
                    if (link_up) begin
                        state_q <= ST_CFG;
                    end
                end

                ST_CFG: begin
                    // Configuration is captured only here; it is frozen for the attempt.
                    delay_x_q <= cfg_delay_x;
                    delay_y_q <= cfg_delay_y;
                    delay_z_q <= cfg_delay_z;
                    timer_q   <= 16'd0;
                    if (!link_up) begin
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                    end else begin
                        state_q     <= ST_TX_UP;
                        tx_online_q <= 1'b1;
                    end
                end

                ST_TX_UP: begin
                    if (!link_up) begin
                        // Link drop: not counted as a failed attempt.
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                        rx_online_q <= 1'b0;
                        timer_q     <= 16'd0;
                    end else if (tx_online_delay) begin
                        // Progress wins over a timeout landing on the same cycle.
                        state_q     <= ST_RX_UP;
                        rx_online_q <= 1'b1;
                        timer_q     <= 16'd0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                        rx_online_q <= 1'b0;
                        retry_q     <= retry_sat_d;
                        timer_q     <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
                        last_fail_q <= 2'd1;
`endif
                    end else begin
                        timer_q <= timer_sat_d;
                    end
                end

                ST_RX_UP: begin
                    if (!link_up) begin
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                        rx_online_q <= 1'b0;
                        timer_q     <= 16'd0;
                    end else if (!tx_online_delay) begin
                        // The tx side fell back while waiting for rx: failed attempt.
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                        rx_online_q <= 1'b0;
                        retry_q     <= retry_sat_d;
                        timer_q     <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
                        last_fail_q <= 2'd3;
`endif
                    end else if (rx_online_delay) begin
                        state_q      <= ST_READY;
                        link_ready_q <= 1'b1;
                        retry_q      <= '0;
                        timer_q      <= 16'd0;
                    end else if (timeout_hit) begin
                        state_q     <= ST_BACKOFF;
                        tx_online_q <= 1'b0;
                        rx_online_q <= 1'b0;
                        retry_q     <= retry_sat_d;
                        timer_q     <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
                        last_fail_q <= 2'd2;
`endif
                    end else begin
                        timer_q <= timer_sat_d;
                    end
                end

                ST_READY: begin
                    if (!link_up) begin
                        state_q      <= ST_BACKOFF;
                        tx_online_q  <= 1'b0;
                        rx_online_q  <= 1'b0;
                        link_ready_q <= 1'b0;
                        timer_q      <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
`endif
                    end
                end

                ST_BACKOFF: begin
                    // Outputs stay low for BACKOFF_CYCLES so downstream delays clear.
                    tx_online_q  <= 1'b0;
                    rx_online_q  <= 1'b0;
                    link_ready_q <= 1'b0;
                    if (timer_q == BACKOFF_LAST) begin
                        timer_q <= 16'd0;
                        if ((cfg_max_retry != '0) && (retry_q >= cfg_max_retry)) begin
                            state_q     <= ST_ERROR;
                            seq_error_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_sat_d;
                    end
                end

                ST_ERROR: begin
                    // Sticky: link_up is ignored, only clear_error leaves.
                    tx_online_q  <= 1'b0;
                    rx_online_q  <= 1'b0;
                    link_ready_q <= 1'b0;
                    seq_error_q  <= 1'b1;
                    if (clear_error) begin
                        state_q     <= ST_IDLE;
                        seq_error_q <= 1'b0;
                        retry_q     <= '0;
                        timer_q     <= 16'd0;
`ifdef LL_ONLINE_SEQ_STATS_EN
                        drop_cnt_q  <= 16'd0;
                        last_fail_q <= 2'd0;
`endif
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    tx_online_q  <= 1'b0;
                    rx_online_q  <= 1'b0;
                    link_ready_q <= 1'b0;
                    timer_q      <= 16'd0;
                end
            endcase
        end
    end

    assign tx_online     = tx_online_q;
    assign rx_online     = rx_online_q;
    assign link_ready    = link_ready_q;
    assign seq_error     = seq_error_q;
    assign retry_cnt     = retry_q;
    assign delay_x_value = delay_x_q;
    assign delay_y_value = delay_y_q;
    assign delay_z_value = delay_z_q;
    assign seq_state     = state_q;
`ifdef LL_ONLINE_SEQ_STATS_EN
    assign stat_drop_cnt  = drop_cnt_q;
    assign stat_last_fail = last_fail_q;
`endif

endmodule
